// File: rtl/step_gate_ct_if.sv
// step_gate_ct_if: core-side handshake between the CPU core and the single-step gate.
interface step_gate_ct_if #(parameter int DATA_WIDTH = 32);
    logic InValid;
    logic [DATA_WIDTH-1:0] InData;
    logic InDataMemReqValid;
    logic InDataMemRespValid;
    logic InClearErr;
    logic OutValid;
    logic [DATA_WIDTH-1:0] OutData;
    logic OutBusy;
    logic OutTimeout;
    logic [31:0] OutStepCount;
    modport master (
        output InValid, InData, InDataMemReqValid, InDataMemRespValid, InClearErr,
        input  OutValid, OutData, OutBusy, OutTimeout, OutStepCount
    );
    modport slave (
        input  InValid, InData, InDataMemReqValid, InDataMemRespValid, InClearErr,
        output OutValid, OutData, OutBusy, OutTimeout, OutStepCount
    );
endinterface

// File: rtl/step_gate_ct.sv
// step_gate_ct: single-step instruction gate with data-memory wait, timeout and
// optional constant-time padding of every step.
module step_gate_ct #(
    parameter int DATA_WIDTH    = 32,
    parameter int STEP_CYCLES   = 2,
    parameter int DRESP_TIMEOUT = 16,
    parameter int CONST_TIME    = 0,
    parameter int STEP_BUDGET   = 24
) (
    input logic Clock,
    input logic Reset,
    step_gate_ct_if.slave Bus
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] STEP       = 3'd1;
    localparam logic [2:0] WAIT_DRESP = 3'd2;
    localparam logic [2:0] PAD        = 3'd3;
    localparam logic [2:0] ERROR      = 3'd4;
    logic [2:0] state;
    logic [3:0] ctr;
    logic [7:0] timer;
    logic [7:0] waitCtr;
    logic [3:0] ctrNext;
    logic [7:0] timerInc;
    logic done;
    logic timedOut;
    assign ctrNext  = ctr + 4'd1;
    assign timerInc = (timer == 8'hFF) ? timer : timer + 8'd1;
    // A response always beats a timeout landing on the same edge.
    assign done = (state == STEP) ? !(Bus.InDataMemReqValid && !Bus.InDataMemRespValid)
                                  : (state == WAIT_DRESP) && Bus.InDataMemRespValid;
    assign timedOut = (state == WAIT_DRESP) && (waitCtr + 8'd1 == 8'(DRESP_TIMEOUT));
    assign Bus.OutBusy = (state != IDLE);
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state            <= IDLE;
            ctr              <= '0;
            timer            <= '0;
            waitCtr          <= '0;
            Bus.OutValid     <= 1'b0;
            Bus.OutData      <= '0;
            Bus.OutTimeout   <= 1'b0;
            Bus.OutStepCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!Bus.InValid) begin
                        ctr <= '0;
                    end else if (ctrNext == 4'(STEP_CYCLES)) begin
                        state            <= STEP;
                        ctr              <= '0;
                        timer            <= 8'd1;
                        waitCtr          <= '0;
                        Bus.OutValid     <= 1'b1;
                        Bus.OutData      <= Bus.InData;
                        Bus.OutStepCount <= Bus.OutStepCount + 32'd1;
                    end else begin
                        ctr <= ctrNext;
                    end
                end
                STEP, WAIT_DRESP: begin
                    timer <= timerInc;
                    if (done) begin
                        state        <= (CONST_TIME != 0) ? PAD : IDLE;
                        Bus.OutValid <= 1'b0;
                    end else if (timedOut) begin
                        state          <= ERROR;
                        Bus.OutValid   <= 1'b0;
                        Bus.OutTimeout <= 1'b1;
                    end else begin
                        state   <= WAIT_DRESP;
                        waitCtr <= (state == WAIT_DRESP) ? waitCtr + 8'd1 : 8'd0;
                    end
                end
                PAD: begin
                    timer <= timerInc;
                    state <= (timer == 8'(STEP_BUDGET)) ? IDLE : PAD;
                end
                ERROR: begin
                    if (Bus.InClearErr) begin
                        state          <= IDLE;
                        ctr            <= '0;
                        Bus.OutTimeout <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_step_gate_ct.sv
// tb_step_gate_ct: directed checks of step_gate_ct, with and without constant-time padding.
module tb_step_gate_ct;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int numCompared = 0;
    int numMismatched = 0;
    int highCnt;
    step_gate_ct_if #(.DATA_WIDTH(32)) bus0 ();
    step_gate_ct_if #(.DATA_WIDTH(32)) bus1 ();
    step_gate_ct #(.DATA_WIDTH(32), .STEP_CYCLES(2), .DRESP_TIMEOUT(16), .CONST_TIME(0), .STEP_BUDGET(24))
        dut0 (.Clock(Clock), .Reset(Reset), .Bus(bus0));
    step_gate_ct #(.DATA_WIDTH(32), .STEP_CYCLES(2), .DRESP_TIMEOUT(16), .CONST_TIME(1), .STEP_BUDGET(24))
        dut1 (.Clock(Clock), .Reset(Reset), .Bus(bus1));
    always #5 Clock = ~Clock;
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numCompared++;
        if (obs !== exp) begin
            numMismatched++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask
    task automatic fire0();
        bus0.InValid = 1'b1;
        tick();
        tick();
        bus0.InValid = 1'b0;
    endtask
    initial begin
        {bus0.InValid, bus0.InDataMemReqValid, bus0.InDataMemRespValid, bus0.InClearErr} = '0;
        {bus1.InValid, bus1.InDataMemReqValid, bus1.InDataMemRespValid, bus1.InClearErr} = '0;
        bus0.InData = '0;
        bus1.InData = '0;
        tick();
        tick();
        checkVal("rst_valid", {31'd0, bus0.OutValid}, 32'd0);
        checkVal("rst_data", bus0.OutData, 32'd0);
        checkVal("rst_busy", {31'd0, bus0.OutBusy}, 32'd0);
        checkVal("rst_timeout", {31'd0, bus0.OutTimeout}, 32'd0);
        checkVal("rst_count", bus0.OutStepCount, 32'd0);
        Reset = 1'b1;
        // Continuous valid: one step every three cycles.
        bus0.InData = 32'hDEADBEEF;
        bus0.InValid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checkVal($sformatf("cont_valid_%0d", k), {31'd0, bus0.OutValid}, (k % 3 == 2) ? 32'd1 : 32'd0);
            if (k % 3 == 2) begin
                checkVal($sformatf("cont_data_%0d", k), bus0.OutData, 32'hDEADBEEF);
                checkVal($sformatf("cont_count_%0d", k), bus0.OutStepCount, 32'(k / 3 + 1));
            end
        end
        bus0.InValid = 1'b0;
        tick();
        // Valid pattern 1,0,1,1 fires only on the fourth edge.
        bus0.InData = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            bus0.InValid = (k != 1);
            tick();
            checkVal($sformatf("pat_valid_%0d", k), {31'd0, bus0.OutValid}, (k == 3) ? 32'd1 : 32'd0);
        end
        bus0.InValid = 1'b0;
        tick();
        checkVal("pat_data", bus0.OutData, 32'h12345678);
        checkVal("pat_count", bus0.OutStepCount, 32'd4);
        // Five cycles waiting for a response, then response.
        fire0();
        highCnt = 1;
        bus0.InDataMemReqValid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            bus0.InDataMemRespValid = (k == 6);
            tick();
            highCnt += int'(bus0.OutValid);
        end
        checkVal("wait_high_cycles", 32'(highCnt), 32'd6);
        checkVal("wait_valid_after", {31'd0, bus0.OutValid}, 32'd0);
        checkVal("wait_timeout", {31'd0, bus0.OutTimeout}, 32'd0);
        checkVal("wait_busy", {31'd0, bus0.OutBusy}, 32'd0);
        checkVal("wait_count", bus0.OutStepCount, 32'd5);
        bus0.InDataMemReqValid = 1'b0;
        bus0.InDataMemRespValid = 1'b0;
        // Response never arrives: timeout after 16 cycles in WAIT_DRESP.
        fire0();
        bus0.InValid = 1'b1;
        bus0.InDataMemReqValid = 1'b1;
        tick();
        for (int k = 1; k <= 15; k++) tick();
        checkVal("to_valid_15", {31'd0, bus0.OutValid}, 32'd1);
        checkVal("to_flag_15", {31'd0, bus0.OutTimeout}, 32'd0);
        tick();
        checkVal("to_valid_16", {31'd0, bus0.OutValid}, 32'd0);
        checkVal("to_flag_16", {31'd0, bus0.OutTimeout}, 32'd1);
        checkVal("to_busy_16", {31'd0, bus0.OutBusy}, 32'd1);
        for (int k = 0; k < 5; k++) tick();
        checkVal("err_busy", {31'd0, bus0.OutBusy}, 32'd1);
        checkVal("err_valid", {31'd0, bus0.OutValid}, 32'd0);
        checkVal("err_count", bus0.OutStepCount, 32'd6);
        checkVal("err_flag", {31'd0, bus0.OutTimeout}, 32'd1);
        bus0.InValid = 1'b0;
        bus0.InDataMemReqValid = 1'b0;
        bus0.InClearErr = 1'b1;
        tick();
        bus0.InClearErr = 1'b0;
        checkVal("clr_busy", {31'd0, bus0.OutBusy}, 32'd0);
        checkVal("clr_flag", {31'd0, bus0.OutTimeout}, 32'd0);
        // Response on the same edge as the timeout wins.
        fire0();
        bus0.InDataMemReqValid = 1'b1;
        tick();
        for (int k = 1; k <= 15; k++) tick();
        bus0.InDataMemRespValid = 1'b1;
        tick();
        checkVal("race_valid", {31'd0, bus0.OutValid}, 32'd0);
        checkVal("race_flag", {31'd0, bus0.OutTimeout}, 32'd0);
        checkVal("race_busy", {31'd0, bus0.OutBusy}, 32'd0);
        bus0.InDataMemRespValid = 1'b0;
        // Asynchronous reset while waiting for a response.
        bus0.InData = 32'hCAFEF00D;
        fire0();
        tick();
        tick();
        checkVal("prerst_valid", {31'd0, bus0.OutValid}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        checkVal("arst_valid", {31'd0, bus0.OutValid}, 32'd0);
        checkVal("arst_count", bus0.OutStepCount, 32'd0);
        checkVal("arst_data", bus0.OutData, 32'd0);
        checkVal("arst_busy", {31'd0, bus0.OutBusy}, 32'd0);
        tick();
        Reset = 1'b1;
        bus0.InDataMemReqValid = 1'b0;
        bus0.InValid = 1'b1;
        tick();
        checkVal("post_rst_1", {31'd0, bus0.OutValid}, 32'd0);
        tick();
        checkVal("post_rst_2", {31'd0, bus0.OutValid}, 32'd1);
        checkVal("post_rst_count", bus0.OutStepCount, 32'd1);
        bus0.InValid = 1'b0;
        tick();
        // Constant-time: plain step padded to 24 cycles, inputs ignored in PAD.
        bus1.InValid = 1'b1;
        tick();
        tick();
        checkVal("ct_fire1", {31'd0, bus1.OutValid}, 32'd1);
        for (int t = 1; t <= 26; t++) begin
            tick();
            if (t <= 24)
                checkVal($sformatf("ct1_busy_%0d", t), {31'd0, bus1.OutBusy}, (t < 24) ? 32'd1 : 32'd0);
            checkVal($sformatf("ct1_valid_%0d", t), {31'd0, bus1.OutValid}, (t == 26) ? 32'd1 : 32'd0);
        end
        // Second step waits five cycles for its response, same 24-cycle footprint.
        bus1.InValid = 1'b0;
        bus1.InDataMemReqValid = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            bus1.InDataMemRespValid = (t == 6);
            if (t == 7) bus1.InDataMemReqValid = 1'b0;
            tick();
            checkVal($sformatf("ct2_busy_%0d", t), {31'd0, bus1.OutBusy}, (t < 24) ? 32'd1 : 32'd0);
            checkVal($sformatf("ct2_valid_%0d", t), {31'd0, bus1.OutValid}, (t <= 5) ? 32'd1 : 32'd0);
        end
        checkVal("ct_count", bus1.OutStepCount, 32'd2);
        checkVal("ct_timeout", {31'd0, bus1.OutTimeout}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end
endmodule
